// File: rtl/game_display_arbiter.sv
// ---------------------------------------------------------------------------
// game_display_arbiter
//
// Purpose:
//   Owns the shared 4-digit seven-segment value and the 16-LED bar and grants
//   them to one game core at a time (classic or infinity). While a game owns
//   the display its segment value and LED level are forwarded with one cycle
//   of latency. When the owner releases, the last forwarded segment value is
//   frozen on the display for HOLD_CYCLES cycles, then the display blanks.
//   Ties are broken in favour of the side that did not own the display last,
//   so after reset classic wins the first tie. An owner is never preempted.
//
// Optional feature (compile-time macro DISP_HOLD_BLINK_EN):
//   When defined, the LED bar blinks the owner's final level during the hold
//   phase, lit first, toggling every BLINK_DIV cycles. When undefined, the LED
//   bar is dark throughout the hold phase and no blink divider exists.
//
// Parameters:
//   HOLD_CYCLES  cycles the final score stays displayed (>= 1)
//   CNT_W        hold-counter width, 2**CNT_W > HOLD_CYCLES
//   BLINK_DIV    blink half-period in cycles (blink build only)
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   req_classic   in   classic requests the display (level)
//   req_infinity  in   infinity requests the display (level)
//   seg_classic   in   [15:0] classic display value
//   seg_infinity  in   [15:0] infinity display value
//   led_classic   in   [4:0]  classic LED level 0..16 (larger saturates)
//   led_infinity  in   [4:0]  infinity LED level 0..16 (larger saturates)
//   blank         in   force-blank switch; zeroes outputs, FSM keeps running
//   gnt_classic   out  classic owns the display
//   gnt_infinity  out  infinity owns the display
//   seg_display   out  [15:0] value to the seven-segment decoder
//   led           out  [15:0] LED bar, thermometer filled from bit 15 down
// ---------------------------------------------------------------------------
module game_display_arbiter #(
  parameter int HOLD_CYCLES = 100000000,
  parameter int CNT_W       = 27,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_classic,
  input  logic        req_infinity,
  input  logic [15:0] seg_classic,
  input  logic [15:0] seg_infinity,
  input  logic [4:0]  led_classic,
  input  logic [4:0]  led_infinity,
  input  logic        blank,
  output logic        gnt_classic,
  output logic        gnt_infinity,
  output logic [15:0] seg_display,
  output logic [15:0] led
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN_C = 2'd1;
  localparam logic [1:0] ST_OWN_I = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // last_owner encoding: 1'b1 = infinity, 1'b0 = classic
  localparam logic OWNER_CLASSIC  = 1'b0;
  localparam logic OWNER_INFINITY = 1'b1;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};

  // Thermometer code: top n bits set, saturating at 16.
  function automatic logic [15:0] therm(input logic [4:0] n);
    logic [15:0] t;
    if (n >= 5'd16) begin
      t = 16'hFFFF;
    end else begin
      t = ~(16'hFFFF >> n);
    end
    return t;
  endfunction

  logic [1:0]       state_r;
  logic [1:0]       state_next_s;
  logic             last_owner_r;
  logic             last_owner_next_s;
  logic [15:0]      hold_r;
  logic [15:0]      hold_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  // Unblanked copies of the outputs; blank only gates the pins, so the value
  // captured into hold_r is never a blanked zero.
  logic [15:0]      seg_norm_r;
  logic [15:0]      seg_norm_next_s;
  logic [15:0]      led_norm_r;
  logic [15:0]      led_norm_next_s;
  logic             pick_classic_s;
  logic             pick_infinity_s;
  logic             hold_entry_s;
  logic [15:0]      hold_entry_led_s;
  logic [15:0]      hold_stay_led_s;

  // Arbitration: a lone requester wins; on a tie the side that did not own
  // the display last wins.
  always_comb begin
    pick_classic_s  = req_classic  & (~req_infinity | (last_owner_r == OWNER_INFINITY));
    pick_infinity_s = req_infinity & (~req_classic  | (last_owner_r == OWNER_CLASSIC));
  end

  // Next-state and next-output logic for the ownership FSM.
  always_comb begin
    state_next_s      = state_r;
    last_owner_next_s = last_owner_r;
    hold_next_s       = hold_r;
    cnt_next_s        = cnt_r;
    seg_norm_next_s   = seg_norm_r;
    led_norm_next_s   = led_norm_r;
    case (state_r)
      ST_IDLE: begin
        seg_norm_next_s = 16'h0000;
        led_norm_next_s = 16'h0000;
        if (pick_classic_s) begin
          state_next_s = ST_OWN_C;
        end else if (pick_infinity_s) begin
          state_next_s = ST_OWN_I;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_OWN_C: begin
        if (req_classic) begin
          seg_norm_next_s = seg_classic;
          led_norm_next_s = therm(led_classic);
        end else begin
          // Freeze what is on the display now; it becomes the hold value.
          state_next_s      = ST_HOLD;
          last_owner_next_s = OWNER_CLASSIC;
          hold_next_s       = seg_norm_r;
          cnt_next_s        = HOLD_LOAD;
          seg_norm_next_s   = seg_norm_r;
          led_norm_next_s   = hold_entry_led_s;
        end
      end
      ST_OWN_I: begin
        if (req_infinity) begin
          seg_norm_next_s = seg_infinity;
          led_norm_next_s = therm(led_infinity);
        end else begin
          state_next_s      = ST_HOLD;
          last_owner_next_s = OWNER_INFINITY;
          hold_next_s       = seg_norm_r;
          cnt_next_s        = HOLD_LOAD;
          seg_norm_next_s   = seg_norm_r;
          led_norm_next_s   = hold_entry_led_s;
        end
      end
      ST_HOLD: begin
        // A request aborts the hold even on the cycle the count expires.
        if (pick_classic_s) begin
          state_next_s    = ST_OWN_C;
          seg_norm_next_s = 16'h0000;
          led_norm_next_s = 16'h0000;
        end else if (pick_infinity_s) begin
          state_next_s    = ST_OWN_I;
          seg_norm_next_s = 16'h0000;
          led_norm_next_s = 16'h0000;
        end else if (cnt_r == CNT_ZERO) begin
          state_next_s    = ST_IDLE;
          seg_norm_next_s = 16'h0000;
          led_norm_next_s = 16'h0000;
        end else begin
          cnt_next_s      = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
          seg_norm_next_s = hold_r;
          led_norm_next_s = hold_stay_led_s;
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        seg_norm_next_s = 16'h0000;
        led_norm_next_s = 16'h0000;
      end
    endcase
  end

  // Marks the edge on which an owner releases and the hold phase begins.
  always_comb begin
    hold_entry_s = (state_next_s == ST_HOLD) && (state_r != ST_HOLD);
  end

`ifdef DISP_HOLD_BLINK_EN
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BLINK_W-1:0] blink_cnt_r;
  logic               blink_on_r;
  logic [15:0]        hold_led_r;
  logic               blink_wrap_s;
  logic               blink_on_next_s;

  // Blink phase for the next hold cycle; lit phase on entry, toggling after
  // BLINK_DIV cycles in each phase.
  always_comb begin
    blink_wrap_s     = (blink_cnt_r == BLINK_W'(BLINK_DIV - 1));
    blink_on_next_s  = blink_wrap_s ? ~blink_on_r : blink_on_r;
    hold_entry_led_s = led_norm_r;
    hold_stay_led_s  = blink_on_next_s ? hold_led_r : 16'h0000;
  end

  // Blink divider and captured final LED level, restarted on every hold entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt_r <= {BLINK_W{1'b0}};
      blink_on_r  <= 1'b0;
      hold_led_r  <= 16'h0000;
    end else if (hold_entry_s) begin
      blink_cnt_r <= {BLINK_W{1'b0}};
      blink_on_r  <= 1'b1;
      hold_led_r  <= led_norm_r;
    end else if (state_r == ST_HOLD) begin
      blink_cnt_r <= blink_wrap_s ? {BLINK_W{1'b0}}
                                  : blink_cnt_r + {{(BLINK_W-1){1'b0}}, 1'b1};
      blink_on_r  <= blink_on_next_s;
    end else begin
      blink_cnt_r <= blink_cnt_r;
      blink_on_r  <= blink_on_r;
    end
  end
`else
  logic unused_blink_div_s;

  // LED bar stays dark for the whole hold phase in this build.
  always_comb begin
    hold_entry_led_s   = 16'h0000;
    hold_stay_led_s    = 16'h0000;
    unused_blink_div_s = (BLINK_DIV > 0) & hold_entry_s;
  end
`endif

  // FSM state, hold bookkeeping and unblanked output values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      last_owner_r <= OWNER_INFINITY;
      hold_r       <= 16'h0000;
      cnt_r        <= CNT_ZERO;
      seg_norm_r   <= 16'h0000;
      led_norm_r   <= 16'h0000;
    end else begin
      state_r      <= state_next_s;
      last_owner_r <= last_owner_next_s;
      hold_r       <= hold_next_s;
      cnt_r        <= cnt_next_s;
      seg_norm_r   <= seg_norm_next_s;
      led_norm_r   <= led_norm_next_s;
    end
  end

  // Registered pins; blank gates only the display, never the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_classic  <= 1'b0;
      gnt_infinity <= 1'b0;
      seg_display  <= 16'h0000;
      led          <= 16'h0000;
    end else begin
      gnt_classic  <= (state_next_s == ST_OWN_C);
      gnt_infinity <= (state_next_s == ST_OWN_I);
      seg_display  <= blank ? 16'h0000 : seg_norm_next_s;
      led          <= blank ? 16'h0000 : led_norm_next_s;
    end
  end

endmodule

// File: doc/game_display_arbiter.md
Name: game_display_arbiter

Overview:
- Owns the shared 4-digit seven-segment value and 16-LED bar and grants them to one game at a time: classic or infinity.
- Each game requests the display, drives its segment value and LED level while granted, then releases it.
- After a release the arbiter keeps the final score on the display for a fixed time, then blanks.
- Sits between the two game cores and the seven-segment decoder and LED pins.

Parameters:
HOLD_CYCLES, 100000000, cycles the final score stays displayed after release (must be >= 1)
CNT_W, 27, hold-counter width (must satisfy 2^CNT_W > HOLD_CYCLES)
BLINK_DIV, 25000000, half-period in cycles of the LED blink during HOLD (optional feature only)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req_classic  input  1  classic game requests display; level, held for the whole session
req_infinity  input  1  infinity game requests display; level
seg_classic  input  16  classic display value
seg_infinity  input  16  infinity display value
led_classic  input  5  classic LED level, 0..16
led_infinity  input  5  infinity LED level, 0..16
blank  input  1  switch-driven force-blank (sw[0])
gnt_classic  output  1  classic currently owns display
gnt_infinity  output  1  infinity currently owns display
seg_display  output  16  value to seven-segment decoder
led  output  16  LED bar, thermometer filled from bit 15 down

Behaviour:
- One clock (clk); asynchronous active-low reset rst_n. All outputs are registered.
- Reset values:
  - state = IDLE
  - gnt_classic = gnt_infinity = 0
  - seg_display = 0, led = 0
  - hold_reg = 0, hold counter = 0
  - last_owner = INFINITY, so classic wins the first tie
- States: IDLE, OWN_C, OWN_I, HOLD.
- IDLE:
  - seg_display = 0, led = 0.
  - Only req_classic -> OWN_C. Only req_infinity -> OWN_I.
  - Both requesting -> the side not equal to last_owner.
  - The gnt output rises one cycle after the req is sampled.
- OWN_C / OWN_I:
  - gnt for the owner = 1.
  - Each cycle, seg_display <= owner seg and led <= therm(owner led); one-cycle latency.
  - The other side's req is ignored; there is no preemption.
  - When the owner's req is sampled low:
    - gnt drops next cycle
    - last_owner <= owner
    - hold_reg <= current seg_display (the last value sampled while req was high)
    - counter <= HOLD_CYCLES-1
    - state -> HOLD
- HOLD:
  - seg_display = hold_reg, led = 0, both gnt = 0.
  - Counter decrements each cycle; at counter = 0 -> IDLE on the next edge. The display therefore shows hold_reg for exactly HOLD_CYCLES cycles.
  - Any req sampled during HOLD aborts the hold and arbitrates exactly as in IDLE, using last_owner.
  - A request on the same cycle the counter reaches 0 also grants; it does not pass through IDLE.
- therm(n):
  - n = 0 -> 0x0000
  - n = k for 1..16 -> top k bits set (1 -> 0x8000, 3 -> 0xE000, 16 -> 0xFFFF)
  - n >= 16 saturates to 0xFFFF
- blank = 1:
  - Forces seg_display = 0 and led = 0 on the next edge.
  - The FSM, grants, hold_reg and counter continue unaffected.
  - Releasing blank restores the normal output on the next edge.
- Reset mid-operation: asynchronous return to the reset values, including a grant in progress; the next tie again favours classic.
- Owner req dropping and the other side's req rising on the same cycle: enter HOLD first, then the other side wins arbitration on the next cycle.

Optional Feature:
DISP_HOLD_BLINK_EN
- Defined:
  - During HOLD, led toggles between therm(last owner's final led level) and 0x0000 every BLINK_DIV cycles.
  - The lit phase comes first on HOLD entry.
  - The blink divider resets on each HOLD entry.
  - The final level is captured with hold_reg.
- Undefined: led = 0 throughout HOLD; no blink divider logic exists.

Test Plan:
- Reset: rst_n low mid-session (OWN_C, seg = 0x1234) -> gnt = 0, seg_display = 0, led = 0 immediately; after release, a simultaneous req grants classic.
- Single owner: req_classic = 1, seg_classic = 0x0042, led_classic = 3 -> gnt_classic = 1 next cycle; seg_display = 0x0042 and led = 0xE000 one cycle later; req_infinity pulses are ignored.
- Fairness: both req held high from IDLE -> classic granted.
  - Classic releases with infinity still requesting -> HOLD for one cycle, then infinity granted.
  - Infinity releases while both request again -> classic granted.
- Hold timing (HOLD_CYCLES = 5): classic releases with last seg 0x0099 -> seg_display = 0x0099 for exactly 5 cycles, then 0; led = 0 during HOLD.
- Hold abort: req_infinity rises at the 2nd HOLD cycle -> gnt_infinity next cycle; seg follows seg_infinity.
- Blank and saturation: blank = 1 while owning with led = 20 -> seg = 0, led = 0 while grants persist; blank = 0 -> led = 0xFFFF. With the macro and BLINK_DIV = 2: HOLD led pattern is level, level, 0, 0, level…
